// File: rtl/usb_host_tx.sv
// Host-side USB full-speed transmitter: serialises bytes into SYNC + NRZI data
// with bit stuffing + EOP, one bit every CLK_DIV cycles of clk48.
module usb_host_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       usb_d_p_o,
  output logic       usb_d_n_o,
  output logic       usb_oe,
  output logic       busy,
  output logic       underrun
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic [2:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       data_r, data_s;
  logic             last_r, last_s;
  logic [2:0]       ones_r, ones_s;
  logic             level_r, level_s;   // 1 = J, 0 = K
  logic             dp_r, dp_s, dn_r, dn_s;
  logic             oe_r, oe_s, busy_r, busy_s, underrun_r, underrun_s;
  logic             bit_end_s, byte_end_s, accept_s;
  logic [2:0]       nxt_idx_s;

  // NRZI step for one transmitted bit: returns {level, ones count, D+, D-}.
  function automatic logic [5:0] nrzi_emit(input logic lvl, input logic [2:0] ones,
                                           input logic b);
    logic       nl;
    logic [2:0] no;
    nl = b ? lvl : ~lvl;
    no = b ? (ones + 3'd1) : 3'd0;
    return {nl, no, nl, ~nl};
  endfunction

  assign bit_end_s  = (div_cnt_r == DIV_LAST);
  // Byte boundary only when no stuff bit is still owed after the last data bit.
  assign byte_end_s = (state_r == DATA) && bit_end_s && (ones_r != 3'd6) && (bit_cnt_r == 3'd7);
  assign data_ready = rst_n && ((state_r == IDLE) || (byte_end_s && !last_r));
  assign accept_s   = data_valid && data_ready;
  assign nxt_idx_s  = bit_cnt_r + 3'd1;

  // Next-state and next-output logic for the packet sequencer.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = bit_end_s ? DIV_ZERO : (div_cnt_r + DIV_W'(1));
    bit_cnt_s  = bit_cnt_r;
    data_s     = data_r;
    last_s     = last_r;
    ones_s     = ones_r;
    level_s    = level_r;
    dp_s       = dp_r;
    dn_s       = dn_r;
    oe_s       = oe_r;
    busy_s     = busy_r;
    underrun_s = 1'b0;
    case (state_r)
      IDLE: begin
        div_cnt_s = DIV_ZERO;
        if (accept_s) begin
          data_s    = data_in;
          last_s    = data_last;
          bit_cnt_s = 3'd0;
          oe_s      = 1'b1;
          busy_s    = 1'b1;
          state_s   = SYNC;
          {level_s, ones_s, dp_s, dn_s} = nrzi_emit(1'b1, 3'd0, 1'b0);
        end else begin
          {level_s, dp_s, dn_s} = 3'b110;
        end
      end
      SYNC: begin
        if (!bit_end_s) begin
          bit_cnt_s = bit_cnt_r;
        end else if (bit_cnt_r == 3'd7) begin
          state_s   = DATA;
          bit_cnt_s = 3'd0;
          {level_s, ones_s, dp_s, dn_s} = nrzi_emit(level_r, ones_r, data_r[0]);
        end else begin
          bit_cnt_s = nxt_idx_s;
          {level_s, ones_s, dp_s, dn_s} = nrzi_emit(level_r, ones_r, (bit_cnt_r == 3'd6));
        end
      end
      DATA: begin
        if (!bit_end_s) begin
          bit_cnt_s = bit_cnt_r;
        end else if (ones_r == 3'd6) begin
          {level_s, ones_s, dp_s, dn_s} = nrzi_emit(level_r, ones_r, 1'b0);
        end else if (bit_cnt_r != 3'd7) begin
          bit_cnt_s = nxt_idx_s;
          {level_s, ones_s, dp_s, dn_s} = nrzi_emit(level_r, ones_r, data_r[nxt_idx_s]);
        end else if (!last_r && data_valid) begin
          data_s    = data_in;
          last_s    = data_last;
          bit_cnt_s = 3'd0;
          {level_s, ones_s, dp_s, dn_s} = nrzi_emit(level_r, ones_r, data_in[0]);
        end else begin
          underrun_s = !last_r;
          state_s    = EOP_SE0;
          bit_cnt_s  = 3'd0;
          {dp_s, dn_s} = 2'b00;
        end
      end
      EOP_SE0: begin
        if (!bit_end_s) begin
          bit_cnt_s = bit_cnt_r;
        end else if (bit_cnt_r == 3'd1) begin
          state_s = EOP_J;
          {level_s, dp_s, dn_s} = 3'b110;
        end else begin
          bit_cnt_s = nxt_idx_s;
        end
      end
      EOP_J: begin
        if (bit_end_s) begin
          state_s   = IDLE;
          bit_cnt_s = 3'd0;
          oe_s      = 1'b0;
          busy_s    = 1'b0;
        end else begin
          state_s = EOP_J;
        end
      end
      default: begin
        state_s   = IDLE;
        div_cnt_s = DIV_ZERO;
        oe_s      = 1'b0;
        busy_s    = 1'b0;
        {level_s, dp_s, dn_s} = 3'b110;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      div_cnt_r  <= DIV_ZERO;
      bit_cnt_r  <= 3'd0;
      data_r     <= 8'd0;
      last_r     <= 1'b0;
      ones_r     <= 3'd0;
      level_r    <= 1'b1;
      dp_r       <= 1'b1;
      dn_r       <= 1'b0;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      data_r     <= data_s;
      last_r     <= last_s;
      ones_r     <= ones_s;
      level_r    <= level_s;
      dp_r       <= dp_s;
      dn_r       <= dn_s;
      oe_r       <= oe_s;
      busy_r     <= busy_s;
      underrun_r <= underrun_s;
    end
  end

  assign usb_d_p_o = dp_r;
  assign usb_d_n_o = dn_r;
  assign usb_oe    = oe_r;
  assign busy      = busy_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_usb_host_tx.sv
// Directed self-checking bench for usb_host_tx: reset/idle, single byte,
// stuffing, back-to-back, underrun and mid-packet reset.
module tb_usb_host_tx;

  localparam logic [1:0] SJ = 2'b10;
  localparam logic [1:0] SK = 2'b01;
  localparam logic [1:0] S0 = 2'b00;

  logic       clk48 = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       usb_d_p_o, usb_d_n_o, usb_oe, busy, underrun;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] pkt [4];
  logic [1:0] obs_q[$];
  logic [1:0] exp_q[$];
  int oe_cnt, rdy_cnt, und_cnt, busy_err;

  usb_host_tx #(.CLK_DIV(4)) dut (
    .clk48(clk48), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .data_ready(data_ready), .usb_d_p_o(usb_d_p_o),
    .usb_d_n_o(usb_d_n_o), .usb_oe(usb_oe), .busy(busy), .underrun(underrun)
  );

  always #5 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference line symbols for nb bytes of pkt: SYNC, stuffed NRZI data, EOP.
  task automatic build_exp(input int nb);
    bit   src[$];
    bit   raw[$];
    int   ones;
    logic lvl;
    exp_q.delete();
    for (int i = 0; i < 8; i++) src.push_back(i == 7);
    for (int k = 0; k < nb; k++)
      for (int j = 0; j < 8; j++) src.push_back(pkt[k][j]);
    ones = 0;
    foreach (src[i]) begin
      raw.push_back(src[i]);
      if (src[i]) ones++; else ones = 0;
      if (ones == 6) begin raw.push_back(1'b0); ones = 0; end
    end
    lvl = 1'b1;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? SJ : SK);
    end
    exp_q.push_back(S0);
    exp_q.push_back(S0);
    exp_q.push_back(SJ);
  endtask

  // Send n bytes of pkt (stop_src drops valid after the first byte) and capture the bus.
  task automatic run_pkt(input string pfx, input int n, input bit stop_src, input int nb_sent,
                         input int oe_exp, input int rdy_exp, input int und_exp);
    int idx;
    bit acc, done;
    int errs;
    oe_cnt = 0; rdy_cnt = 0; und_cnt = 0; busy_err = 0; idx = 0; done = 0;
    obs_q.delete();
    data_in = pkt[0]; data_last = (n == 1); data_valid = 1'b1;
    for (int c = 0; c < 1000 && !done; c++) begin
      acc = data_valid && data_ready;
      if (usb_oe && data_ready) rdy_cnt++;
      @(posedge clk48);
      @(negedge clk48);
      if (acc) begin
        idx++;
        if (idx < n && !stop_src) begin
          data_in = pkt[idx]; data_last = (idx == n - 1);
        end else begin
          data_valid = 1'b0;
        end
      end
      if (underrun) und_cnt++;
      if (busy !== usb_oe) busy_err++;
      if (usb_oe) obs_q.push_back({usb_d_p_o, usb_d_n_o});
      if (usb_oe) oe_cnt++;
      else if (idx > 0) done = 1;
    end
    chk({pfx, "_done"}, done, 1);
    build_exp(nb_sent);
    errs = 0;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i / 4]) errs++;
    chk({pfx, "_line_errs"}, errs, 0);
    chk({pfx, "_oe_cycles"}, oe_cnt, oe_exp);
    chk({pfx, "_ready_pulses"}, rdy_cnt, rdy_exp);
    chk({pfx, "_underrun"}, und_cnt, und_exp);
    chk({pfx, "_busy_vs_oe"}, busy_err, 0);
    chk({pfx, "_idle_line"}, {usb_d_p_o, usb_d_n_o, data_ready}, 3'b101);
  endtask

  initial begin
    int act;
    logic [37:0] packed_obs;
    rst_n = 1'b0; data_valid = 1'b1; data_in = 8'h55; data_last = 1'b1;
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    chk("rst_oe", usb_oe, 0);
    chk("rst_line", {usb_d_p_o, usb_d_n_o}, 2'b10);
    chk("rst_ready", data_ready, 0);
    chk("rst_busy_underrun", {busy, underrun}, 2'b00);
    data_valid = 1'b0;
    rst_n = 1'b1;
    act = 0;
    repeat (100) begin
      @(negedge clk48);
      if (usb_oe || busy || underrun || !usb_d_p_o || usb_d_n_o || !data_ready) act++;
    end
    chk("idle_activity", act, 0);

    pkt[0] = 8'hA5;
    run_pkt("a5", 1, 1'b0, 1, 76, 0, 0);
    packed_obs = '0;
    if (obs_q.size() >= 76)
      for (int i = 0; i < 19; i++) packed_obs = {packed_obs[35:0], obs_q[4 * i + 1]};
    chk("a5_hand_line", packed_obs,
        {SK, SJ, SK, SJ, SK, SJ, SK, SK, SK, SJ, SJ, SK, SJ, SJ, SK, SK, S0, S0, SJ});

    pkt[0] = 8'hFF;
    run_pkt("ff", 1, 1'b0, 1, 80, 0, 0);
    packed_obs = '0;
    if (obs_q.size() >= 80)
      for (int i = 8; i < 17; i++) packed_obs = {packed_obs[35:0], obs_q[4 * i + 1]};
    chk("ff_stuff_line", packed_obs[17:0], {SK, SK, SK, SK, SK, SJ, SJ, SJ, SJ});

    pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt[2] = 8'h00;
    run_pkt("b2b", 3, 1'b0, 3, 148, 2, 0);

    pkt[0] = 8'h3C;
    run_pkt("undr", 2, 1'b1, 1, 76, 1, 1);

    // Mid-packet reset during data bit 3 of 0xA5.
    pkt[0] = 8'hA5;
    data_in = 8'hA5; data_last = 1'b1; data_valid = 1'b1;
    @(posedge clk48);
    @(negedge clk48);
    data_valid = 1'b0;
    repeat (45) @(negedge clk48);
    chk("mid_oe_before", usb_oe, 1);
    rst_n = 1'b0;
    @(posedge clk48);
    @(negedge clk48);
    chk("mid_rst_oe", {usb_oe, busy}, 2'b00);
    chk("mid_rst_line", {usb_d_p_o, usb_d_n_o}, 2'b10);
    rst_n = 1'b1;
    @(negedge clk48);
    chk("mid_rst_line_after", {usb_oe, usb_d_p_o, usb_d_n_o}, 3'b010);
    run_pkt("resend", 1, 1'b0, 1, 76, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
